// File: rtl/move_sequencer.sv
// Queued register move/swap sequencer driving a 2R1W register file.
// Define MOVE_SEQ_SWAP_EN to enable true swaps; otherwise op=0 executes as a move.
module move_sequencer #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_op,
  input  logic [2:0]                    cmd_dst,
  input  logic [2:0]                    cmd_src,
  output logic [2:0]                    rf_raddr0,
  output logic [2:0]                    rf_raddr1,
  input  logic [31:0]                   rf_rdata0,
  input  logic [31:0]                   rf_rdata1,
  output logic                          rf_we,
  output logic [2:0]                    rf_waddr,
  output logic [31:0]                   rf_wdata,
  output logic                          done,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam logic [PtrW:0] FullCount = FIFO_DEPTH[PtrW:0];

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRead  = 2'd1;
  localparam logic [1:0] StWrDst = 2'd2;
  localparam logic [1:0] StWrSrc = 2'd3;

  logic [6:0]      mem [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   count_q, count_d;
  logic [1:0]      state_q, state_d;
  logic            cmd_op_q, cmd_op_d;
  logic [2:0]      cmd_dst_q, cmd_dst_d;
  logic [2:0]      cmd_src_q, cmd_src_d;
  logic [31:0]     opnd0_q, opnd0_d;
  logic [31:0]     opnd1_q, opnd1_d;
  logic            push, pop;

  // Ready depends only on registered occupancy; a pop never frees a slot in the same cycle.
  assign cmd_ready  = (count_q != FullCount);
  assign push       = cmd_valid & cmd_ready;
  assign pop        = (state_q == StIdle) && (count_q != '0);
  assign fifo_count = count_q;
  assign busy       = (state_q != StIdle) || (count_q != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= {cmd_op, cmd_dst, cmd_src};
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (PtrW + 1)'(1);
      2'b01:   count_d = count_q - (PtrW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cmd_op_d  = cmd_op_q;
    cmd_dst_d = cmd_dst_q;
    cmd_src_d = cmd_src_q;
    opnd0_d   = opnd0_q;
    opnd1_d   = opnd1_q;
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          {cmd_op_d, cmd_dst_d, cmd_src_d} = mem[rd_ptr_q];
          state_d = StRead;
        end
      end
      StRead: begin
        opnd0_d = rf_rdata0;
        opnd1_d = rf_rdata1;
        state_d = StWrDst;
      end
      StWrDst: begin
`ifdef MOVE_SEQ_SWAP_EN
        // A swap of a register with itself needs only the one write.
        if (!cmd_op_q && (cmd_dst_q != cmd_src_q)) begin
          state_d = StWrSrc;
        end else begin
          state_d = StIdle;
        end
`else
        state_d = StIdle;
`endif
      end
`ifdef MOVE_SEQ_SWAP_EN
      StWrSrc: state_d = StIdle;
`endif
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rf_raddr0 = '0;
    rf_raddr1 = '0;
    rf_we     = 1'b0;
    rf_waddr  = '0;
    rf_wdata  = '0;
    done      = 1'b0;
    unique case (state_q)
      StRead: begin
        rf_raddr0 = cmd_dst_q;
        rf_raddr1 = cmd_src_q;
      end
      StWrDst: begin
        rf_we    = 1'b1;
        rf_waddr = cmd_dst_q;
        rf_wdata = opnd1_q;
        done     = (state_d == StIdle);
      end
`ifdef MOVE_SEQ_SWAP_EN
      StWrSrc: begin
        rf_we    = 1'b1;
        rf_waddr = cmd_src_q;
        rf_wdata = opnd0_q;
        done     = 1'b1;
      end
`endif
      default: ;
    endcase
  end

`ifndef MOVE_SEQ_SWAP_EN
  logic unused_swap_state;
  assign unused_swap_state = ^{cmd_op_q, opnd0_q};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      state_q   <= StIdle;
      cmd_op_q  <= 1'b0;
      cmd_dst_q <= '0;
      cmd_src_q <= '0;
      opnd0_q   <= '0;
      opnd1_q   <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      state_q   <= state_d;
      cmd_op_q  <= cmd_op_d;
      cmd_dst_q <= cmd_dst_d;
      cmd_src_q <= cmd_src_d;
      opnd0_q   <= opnd0_d;
      opnd1_q   <= opnd1_d;
    end
  end

endmodule

// File: tb/tb_move_sequencer.sv
// Scoreboard bench for move_sequencer: a register-file model plus a queue-based reference
// that predicts every write (address, data, done) and the inter-command timing.
module tb_move_sequencer;

  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_op;
  logic [2:0]    cmd_dst, cmd_src;
  logic [2:0]    rf_raddr0, rf_raddr1, rf_waddr;
  logic [31:0]   rf_rdata0, rf_rdata1, rf_wdata;
  logic          rf_we, done, busy;
  logic [CW-1:0] fifo_count;

  // Backdoor register load, applied to both the environment file and the reference.
  logic          bd_we;
  logic [2:0]    bd_addr;
  logic [31:0]   bd_data;
  logic          stim_done;

  always #5 clk = ~clk;

  move_sequencer #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_dst(cmd_dst), .cmd_src(cmd_src), .rf_raddr0(rf_raddr0), .rf_raddr1(rf_raddr1),
    .rf_rdata0(rf_rdata0), .rf_rdata1(rf_rdata1), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .done(done), .busy(busy), .fifo_count(fifo_count)
  );

  logic [31:0] rf [8] = '{default: 32'h0};
  assign rf_rdata0 = rf[rf_raddr0];
  assign rf_rdata1 = rf[rf_raddr1];

  always @(posedge clk) begin
    if (rf_we) rf[rf_waddr] <= rf_wdata;
    if (bd_we) rf[bd_addr] <= bd_data;
  end

  // ---------------- reference model + monitor ----------------
  typedef struct { logic op; logic [2:0] dst; logic [2:0] src; } cmd_t;
  typedef struct { logic [2:0] a; logic [31:0] d; } wr_t;

  cmd_t        mq[$];
  wr_t         pend[$];
  logic [31:0] ref_rf [8] = '{default: 32'h0};
  int          n_cmp = 0, n_fail = 0;
  int          since_done = 100, drain = 0, cycles = 0;
  bit          tight = 0, rst_seen = 0, saw_full = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic finish_run();
    chk("saw_full_backpressure", 32'(saw_full), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  endtask

  always @(negedge clk) begin
    cmd_t c;
    wr_t  w;
    cycles++;
    since_done++;
    if (bd_we) ref_rf[bd_addr] = bd_data;
    if (rst_seen) begin
      chk("rst_fifo_count", 32'(fifo_count), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_rf_we", 32'(rf_we), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
    end
    chk("cmd_ready_vs_count", 32'(cmd_ready), 32'(fifo_count != CW'(FIFO_DEPTH)));
    if (fifo_count == CW'(FIFO_DEPTH) && !cmd_ready) saw_full = 1;

    if (rf_we) begin
      if (pend.size() == 0) begin
        if (mq.size() == 0) begin
          chk("unexpected_write", 32'(rf_waddr), 32'hFFFF_FFFF);
        end else begin
          c = mq.pop_front();
          if (tight) chk("next_cmd_latency", since_done, 3);
          else       chk("min_cmd_latency", 32'(since_done >= 3), 32'd1);
`ifdef MOVE_SEQ_SWAP_EN
          if (!c.op && c.dst != c.src) begin
            pend.push_back('{a: c.dst, d: ref_rf[c.src]});
            pend.push_back('{a: c.src, d: ref_rf[c.dst]});
          end else begin
            pend.push_back('{a: c.dst, d: ref_rf[c.src]});
          end
`else
          pend.push_back('{a: c.dst, d: ref_rf[c.src]});
`endif
        end
      end
      if (pend.size() != 0) begin
        w = pend.pop_front();
        chk("waddr", 32'(rf_waddr), 32'(w.a));
        chk("wdata", rf_wdata, w.d);
        chk("done_on_last", 32'(done), 32'(pend.size() == 0));
        ref_rf[w.a] = w.d;
      end
      if (done) begin
        since_done = 0;
        tight = (mq.size() != 0);
      end
    end else begin
      if (pend.size() != 0) begin
        chk("swap_second_write_missing", 32'(rf_we), 32'd1);
        pend.delete();
      end
      chk("idle_waddr", 32'(rf_waddr), 32'd0);
      chk("idle_wdata", rf_wdata, 32'd0);
      chk("idle_done", 32'(done), 32'd0);
    end

    if (rst) begin
      mq.delete();
      pend.delete();
      since_done = 100;
      tight = 0;
      rst_seen = 1;
    end else begin
      rst_seen = 0;
      if (cmd_valid && cmd_ready) mq.push_back('{op: cmd_op, dst: cmd_dst, src: cmd_src});
    end

    if (stim_done) begin
      if (mq.size() == 0 && pend.size() == 0 && !busy) finish_run();
      else if (++drain > 2000) begin
        chk("drain_timeout", 32'(mq.size() + pend.size()), 32'd0);
        finish_run();
      end
    end else if (cycles > 60000) begin
      chk("stimulus_timeout", 32'(cycles), 32'd0);
      finish_run();
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setr(input logic [2:0] a, input logic [31:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    tick();
    bd_we = 1'b0;
  endtask

  task automatic send(input logic op, input logic [2:0] dst, input logic [2:0] src);
    int t = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_dst = dst; cmd_src = src;
    do @(negedge clk); while (!cmd_ready && ++t < 500);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    do @(negedge clk); while (busy && ++t < 1000);
    tick();
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_dst = '0; cmd_src = '0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0; stim_done = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    setr(3'd1, 32'h1111_1111); setr(3'd2, 32'h2222_2222);
    send(1'b1, 3'd1, 3'd2); wait_idle();
    setr(3'd1, 32'h1111_1111); setr(3'd2, 32'h2222_2222);
    send(1'b0, 3'd1, 3'd2); wait_idle();
    setr(3'd3, 32'hDEAD_BEEF);
    send(1'b0, 3'd3, 3'd3); wait_idle();
    setr(3'd2, 32'hA5A5_A5A5);
    send(1'b1, 3'd1, 3'd2); send(1'b1, 3'd3, 3'd1); wait_idle();

    for (int i = 0; i < 8; i++) begin
      setr(3'(i), $urandom);
    end
    for (int i = 0; i < 8; i++) begin
      send(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end
    wait_idle();

    // Reset lands during the first write of a command with two more queued behind it.
    send(1'b0, 3'd1, 3'd2); send(1'b1, 3'd3, 3'd4); send(1'b1, 3'd5, 3'd6);
    for (int t = 0; t < 20 && !rf_we; t++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) tick();

    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      send(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end
    wait_idle();
    stim_done = 1'b1;
  end

endmodule

// File: doc/move_sequencer.md
MOVE_SEQUENCER -- requirements
Module: move_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, command queue depth; SHALL be a power of two, minimum 2.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 cmd_valid  input  1  command offered this cycle.
REQ-005 cmd_ready  output  1  queue can accept; a command transfers on the edge where cmd_valid&cmd_ready.
REQ-006 cmd_op  input  1  1 = move (src -> dst), 0 = swap (dst <-> src).
REQ-007 cmd_dst  input  3  destination register index (operand 0).
REQ-008 cmd_src  input  3  source register index (operand 1).
REQ-009 rf_raddr0 / rf_raddr1  output  3 each  register-file read addresses, combinational read.
REQ-010 rf_rdata0 / rf_rdata1  input  32 each  read data for raddr0 / raddr1, same cycle.
REQ-011 rf_we  output  1  register-file write enable, single write port.
REQ-012 rf_waddr  output  3  write address.
REQ-013 rf_wdata  output  32  write data.
REQ-014 done  output  1  one-cycle pulse on final write of each command.
REQ-015 busy  output  1  high when FSM not IDLE or queue non-empty.
REQ-016 fifo_count  output  $clog2(FIFO_DEPTH)+1  current queue occupancy.

Function
REQ-017 Queue SHALL be FIFO-ordered; cmd_ready = (fifo_count != FIFO_DEPTH), registered-state only, no same-cycle pop bypass.
REQ-018 FSM states SHALL be IDLE, READ, WR_DST, WR_SRC; each occupies exactly one cycle.
REQ-019 IDLE: if queue non-empty, pop head into command register and go to READ; else stay.
REQ-020 READ: rf_raddr0 = dst, rf_raddr1 = src; latch rf_rdata0 into opnd0, rf_rdata1 into opnd1; go to WR_DST.
REQ-021 WR_DST: rf_we=1, rf_waddr=dst, rf_wdata=opnd1; move or (swap with dst==src) -> done=1, go IDLE; otherwise swap -> WR_SRC.
REQ-022 WR_SRC: rf_we=1, rf_waddr=src, rf_wdata=opnd0, done=1, go IDLE.
REQ-023 Latency: pop cycle to final write is 2 cycles for move, 3 for swap; command accepted on edge E is popped no earlier than the cycle after E.
REQ-024 rf_we SHALL be 0 in IDLE and READ; rf_raddr*/rf_waddr/rf_wdata SHALL be 0 when unused.
REQ-025 Back-to-back: next pop occurs in the IDLE cycle following the final write, so READ of a dependent command sees prior writes.
REQ-026 Push while full SHALL be ignored (cmd_ready=0); push and pop in same cycle SHALL leave fifo_count unchanged.
REQ-027 Read/write pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-028 On rst: FSM=IDLE, queue emptied, fifo_count=0, cmd_ready=1, rf_we=0, done=0, busy=0, all address/data outputs 0, opnd0/opnd1=0.
REQ-029 Reset mid-command SHALL abort it with no further rf_we; queued commands are discarded.

Configuration
REQ-030 Macro MOVE_SEQ_SWAP_EN: defined -> swaps per REQ-021/022.
REQ-031 Undefined -> WR_SRC state omitted; cmd_op=0 executes as a move (single write, done on WR_DST).

Verification
REQ-032 R1=0x11111111, R2=0x22222222; move dst=1 src=2 -> one write R1=0x22222222 two cycles after pop, done once, R2 unchanged.
REQ-033 Same init, swap dst=1 src=2 (SWAP_EN) -> writes R1=0x22222222 then R2=0x11111111 on consecutive cycles, done on second.
REQ-034 Swap dst=src=3, R3=0xDEADBEEF -> single write of 0xDEADBEEF, done on WR_DST.
REQ-035 Push 5 commands back-to-back with FIFO_DEPTH=4 while executing -> cmd_ready low at count 4, all accepted commands executed in order, none lost or duplicated.
REQ-036 Move 2->1 then move 1->3 back-to-back, R2=0xA5A5A5A5 -> R3=0xA5A5A5A5 (dependency honoured).
REQ-037 Assert rst during WR_DST of a swap with 2 queued -> no rf_we after reset edge, fifo_count=0, busy=0, cmd_ready=1.
